// File: rtl/da2_sched_pkg.sv
// Shared definitions for the da2 write scheduler: FSM encoding, da2 channel modes
// and the default sample width.
package da2_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_A_ONLY = 2'd0;
  localparam logic [1:0] MODE_B_ONLY = 2'd1;
  localparam logic [1:0] MODE_BOTH   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam int DEFAULT_DATA_W = 12;

endpackage

// File: rtl/da2_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr (wrapping) and
// returns a one-hot grant for the first active request.
module rr_arbiter
  import da2_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/da2_sched.sv
// Round-robin scheduler sharing one da2 core among NUM_REQ requesters.
// Optional SYNC-fall watchdog with sticky err port: define DA2_SCHED_TIMEOUT_EN.
module da2_sched
  import da2_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*2-1:0]         req_mode,
  output logic [NUM_REQ-1:0]           ack,
  output logic [DATA_W-1:0]            dac_val,
  output logic [1:0]                   dac_mode,
  output logic                         dac_update,
  input  logic                         dac_sync,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
`ifdef DA2_SCHED_TIMEOUT_EN
  ,
  output logic                         err
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("da2_sched: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_t         state_reg, state_next;
  logic           sync_meta_reg, sync_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] win_id;
  logic [NUM_REQ-1:0] win;
  logic           load;
  logic           timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (win)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_id = IDW'(i);
    end
  end

`ifdef DA2_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  // A SYNC fall on the final allowed cycle still wins over the timeout.
  assign timeout_hit = (state_reg == ST_WAIT_LOW) && sync_reg && (cnt_reg == CW'(TIMEOUT - 1));
  assign err         = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= (state_reg == ST_WAIT_LOW) ? cnt_reg + 1'b1 : '0;
      if (timeout_hit) err_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          load       = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: begin
        if (!sync_reg)        state_next = ST_WAIT_HIGH;
        else if (timeout_hit) state_next = ST_IDLE;
      end
      ST_WAIT_HIGH: if (sync_reg) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // The pointer moves past the winner at grant time, so a timed-out requester
  // is already behind the others when the FSM returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      sync_meta_reg <= 1'b1;
      sync_reg      <= 1'b1;
      ptr_reg       <= '0;
      dac_val       <= '0;
      dac_mode      <= MODE_A_ONLY;
      grant_id      <= '0;
    end else begin
      state_reg     <= state_next;
      sync_meta_reg <= dac_sync;
      sync_reg      <= sync_meta_reg;
      if (load) begin
        dac_val  <= req_data[win_id*DATA_W +: DATA_W];
        dac_mode <= req_mode[win_id*2 +: 2];
        grant_id <= win_id;
        ptr_reg  <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  assign dac_update = (state_reg == ST_ISSUE);
  assign busy       = (state_reg != ST_IDLE);

  always_comb begin
    ack = '0;
    if (state_reg == ST_DONE) ack[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_da2_sched.sv
// Directed bench for da2_sched with a behavioural da2 SYNC responder.
// Build with DA2_SCHED_TIMEOUT_EN to also exercise the SYNC-fall watchdog.
module tb_da2_sched;

  localparam int N = 4;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N*2-1:0] req_mode = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   dac_val;
  logic [1:0]     dac_mode;
  logic           dac_update;
  logic           dac_sync = 1'b1;
  logic           busy;
  logic [1:0]     grant_id;
`ifdef DA2_SCHED_TIMEOUT_EN
  logic           err;
`endif

  int  tests = 0;
  int  fails = 0;
  int  cycle = 0;
  int  upd_count = 0;
  int  ack_count = 0;
  int  rise_cycle = -1;
  logic prev_sync = 1'b1;
  bit  sync_en = 1'b1;
  int  fc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

`ifdef DA2_SCHED_TIMEOUT_EN
  da2_sched #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .ack(ack), .dac_val(dac_val), .dac_mode(dac_mode), .dac_update(dac_update),
    .dac_sync(dac_sync), .busy(busy), .grant_id(grant_id), .err(err)
  );
`else
  da2_sched #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .ack(ack), .dac_val(dac_val), .dac_mode(dac_mode), .dac_update(dac_update),
    .dac_sync(dac_sync), .busy(busy), .grant_id(grant_id)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // da2 model: SYNC drops two cycles after the update pulse and stays low six cycles.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      fc = 0;
      dac_sync = 1'b1;
    end else begin
      if (fc > 0) fc++;
      if (dac_update && sync_en && fc == 0) fc = 1;
      if (fc > 8) fc = 0;
      dac_sync = !(fc >= 3);
    end
  end

  always @(posedge clk) begin
    #2;
    if (!prev_sync && dac_sync) rise_cycle = cycle;
    prev_sync = dac_sync;
    if (dac_update) upd_count++;
    if (ack != '0) begin
      ack_count++;
      check("ack_onehot", 32'($countones(ack)), 32'd1);
      $display("[TB] ack %b grant_id %0d dac_val %03h at cycle %0d", ack, grant_id, dac_val, cycle);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_update(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #3;
      if (dac_update) begin
        c = cycle;
        return;
      end
    end
    check("update_timeout", 32'(dac_update), 32'd1);
  endtask

  task automatic wait_ack(output int idx, output int c);
    idx = -1;
    c   = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #3;
      if (ack != '0) begin
        for (int b = 0; b < N; b++) if (ack[b]) idx = b;
        c = cycle;
        return;
      end
    end
    check("ack_timeout", 32'(ack != '0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  int exp3 [5] = '{0, 1, 2, 3, 0};

  initial begin
    int cu, ca, idx, a0, u0;

    // reset state
    step(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_update", 32'(dac_update), 32'd0);
    check("rst_val", 32'(dac_val), 32'd0);
    check("rst_mode", 32'(dac_mode), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
`ifdef DA2_SCHED_TIMEOUT_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b1;
    step(2);

    // single request on index 2
    req_data[2*W +: W] = 12'hABC;
    req_mode[5:4] = 2'd0;
    u0 = upd_count;
    req[2] = 1'b1;
    wait_update(cu);
    check("t2_val", 32'(dac_val), 32'hABC);
    check("t2_mode", 32'(dac_mode), 32'd0);
    check("t2_grant", 32'(grant_id), 32'd2);
    wait_ack(idx, ca);
    req[2] = 1'b0;
    check("t2_ack_idx", 32'(idx), 32'd2);
    check("t2_sync_to_ack", 32'(ca - rise_cycle), 32'd3);
    check("t2_updates", 32'(upd_count - u0), 32'd1);
    step(1);
    check("t2_ack_single", 32'(ack), 32'd0);

    // all four held: rotation from index 0 after reset
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 12'(12'h100 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, ca);
      if (k == 4) req = '0;
      check($sformatf("t3_order%0d", k), 32'(idx), 32'(exp3[k]));
      check($sformatf("t3_val%0d", k), 32'(dac_val), 32'(12'h100 + exp3[k]));
    end

    // late request on index 1 issues two cycles after ack[0]
    req_data[0 +: W] = 12'h055;
    req[0] = 1'b1;
    wait_update(cu);
    step(2);
    req[1] = 1'b1;
    wait_ack(idx, ca);
    req[0] = 1'b0;
    check("t4_first", 32'(idx), 32'd0);
    wait_update(cu);
    check("t4_gap", 32'(cu - ca), 32'd2);
    check("t4_grant", 32'(grant_id), 32'd1);
    wait_ack(idx, ca);
    req[1] = 1'b0;
    check("t4_second", 32'(idx), 32'd1);

    // input change after latch is ignored
    req_data[3*W +: W] = 12'h123;
    req_mode[7:6] = 2'd3;
    req[3] = 1'b1;
    wait_update(cu);
    req_data[3*W +: W] = 12'hFFF;
    req_mode[7:6] = 2'd1;
    step(3);
    check("t5_val_mid", 32'(dac_val), 32'h123);
    wait_ack(idx, ca);
    req[3] = 1'b0;
    check("t5_val_done", 32'(dac_val), 32'h123);
    check("t5_mode_done", 32'(dac_mode), 32'd3);

    // reset in WAIT_HIGH aborts and restarts priority at 0
    req_data[2*W +: W] = 12'h2AA;
    req_data[0 +: W] = 12'h0A0;
    req[2] = 1'b1;
    wait_update(cu);
    step(6);
    check("t6_busy_pre", 32'(busy), 32'd1);
    a0 = ack_count;
    req = 4'b1001;
    rst = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_update", 32'(dac_update), 32'd0);
    check("t6_val", 32'(dac_val), 32'd0);
    check("t6_grant_rst", 32'(grant_id), 32'd0);
    step(2);
    rst = 1'b1;
    wait_update(cu);
    check("t6_no_ack", 32'(ack_count - a0), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    wait_ack(idx, ca);
    req[0] = 1'b0;
    check("t6_ack0", 32'(idx), 32'd0);
    wait_ack(idx, ca);
    req = '0;
    check("t6_ack3", 32'(idx), 32'd3);

`ifdef DA2_SCHED_TIMEOUT_EN
    // SYNC never falls: watchdog fires after 16 WAIT_LOW cycles
    step(2);
    sync_en = 1'b0;
    a0 = ack_count;
    req[1] = 1'b1;
    wait_update(cu);
    for (int n = 0; n < 40; n++) begin
      step(1);
      if (err) break;
    end
    check("t7_err_latency", 32'(cycle - cu), 32'd17);
    check("t7_err", 32'(err), 32'd1);
    check("t7_busy", 32'(busy), 32'd0);
    req[1] = 1'b0;
    step(3);
    check("t7_no_ack", 32'(ack_count - a0), 32'd0);
    check("t7_sticky", 32'(err), 32'd1);
    sync_en = 1'b1;
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
